// File: rtl/binary_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM state encoding, allowed chunk widths and counter sizing.
package binary_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam int BPC_1 = 1;
  localparam int BPC_2 = 2;
  localparam int BPC_4 = 4;

  // Counter must hold the iteration count n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/binary_mul_pp_step.sv
// Combinational partial-product former for one multiplier chunk.
// The multiplicand arrives already extended and shifted to the chunk's
// weight. When the chunk holds the multiplier MSB of a signed operation,
// that top bit carries negative weight and its term is subtracted.
module binary_mul_pp_step
  import binary_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic [BPC-1:0]     chunk_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic               msb_chunk_i,
  input  logic               signed_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] pp_s;

  // Sum (or subtract, for the signed MSB) the shifted multiplicand per set bit.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < BPC; i++) begin
      if (chunk_i[i]) begin
        if ((i == BPC - 1) && msb_chunk_i && signed_i) begin
          pp_s = pp_s - (mcand_i << i);
        end else begin
          pp_s = pp_s + (mcand_i << i);
        end
      end else begin
        pp_s = pp_s;
      end
    end
  end

  assign pp_o = pp_s;

endmodule

// File: rtl/binary_mul_seq.sv
// Iterative shift-add multiplier, BPC multiplier bits per cycle, exact
// 2*WIDTH-bit product, per-operation signed/unsigned mode.
// Optional feature macro: BINARY_MUL_SEQ_EARLY_TERM_EN -- finish as soon as
// the remaining multiplier bits are all zero (variable latency, same result).
module binary_mul_seq
  import binary_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(N);
  localparam int PW = 2 * WIDTH;

  if (!((BPC == BPC_1) || (BPC == BPC_2) || (BPC == BPC_4)) || (WIDTH % BPC != 0)) begin : g_bad_cfg
    $error("binary_mul_seq: BPC must be 1, 2 or 4 and divide WIDTH");
  end

  mul_state_t        state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              sgn_q, sgn_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;

  logic [PW-1:0]     pp_s;
  logic [PW-1:0]     acc_sum_s;
  logic [WIDTH-1:0]  mplier_shr_s;
  logic              msb_chunk_s;
  logic              last_chunk_s;

  assign msb_chunk_s  = (cnt_q == CW'(1));
  assign mplier_shr_s = mplier_q >> BPC;
  assign acc_sum_s    = acc_q + pp_s;

`ifdef BINARY_MUL_SEQ_EARLY_TERM_EN
  // Nothing left to add once the unprocessed multiplier bits are all zero.
  assign last_chunk_s = msb_chunk_s || (mplier_shr_s == '0);
`else
  assign last_chunk_s = msb_chunk_s;
`endif

  binary_mul_pp_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_pp_step (
    .chunk_i     (mplier_q[BPC-1:0]),
    .mcand_i     (mcand_q),
    .msb_chunk_i (msb_chunk_s),
    .signed_i    (sgn_q),
    .pp_o        (pp_s)
  );

  // Next-state, datapath and handshake logic; en low freezes everything.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      ST_IDLE: begin
        if (en && in_valid) begin
          state_d  = ST_BUSY;
          acc_d    = '0;
          mcand_d  = in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
          mplier_d = b;
          sgn_d    = in_signed;
          cnt_d    = CW'(N);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (en) begin
          // Multiplicand shifts up as the multiplier shifts down, keeping weights aligned.
          acc_d    = acc_sum_s;
          mcand_d  = mcand_q << BPC;
          mplier_d = mplier_shr_s;
          cnt_d    = cnt_q - CW'(1);
          if (last_chunk_s) begin
            state_d = ST_DONE;
            p_d     = acc_sum_s;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (en && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Handshake flags decode the state register only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_binary_mul_seq.sv
// Self-checking bench for binary_mul_seq: three instances (BPC 1, 2, 4,
// WIDTH 16) checked against an arithmetic product/latency model.
module tb_binary_mul_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           en;
  logic           in_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           in_valid  [3];
  logic           out_ready [3];
  logic           in_ready  [3];
  logic           out_valid [3];
  logic [2*W-1:0] p         [3];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    binary_mul_seq #(.WIDTH(W), .BPC(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_signed (in_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .p         (p[g])
    );
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference product: plain integer multiply of the interpreted operands.
  function automatic logic [31:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint xv;
    longint yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return 32'(xv * yv);
  endfunction

  // Reference latency in BUSY cycles.
  function automatic int model_lat(input logic [W-1:0] y, input int bpc);
    int n;
    n = W / bpc;
`ifdef BINARY_MUL_SEQ_EARLY_TERM_EN
    for (int k = 1; k <= n; k++) begin
      if ((32'(y) >> (k * bpc)) == 32'd0) return k;
    end
`endif
    return n;
  endfunction

  // One full transaction on instance g with latency, product, backpressure and return checks.
  task automatic run_op(input int g, input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input int hold, input int drop_at, input int drop_len);
    logic [31:0] exp_p;
    int exp_lat;
    int cyc;
    int wait_cyc;
    exp_p   = model_prod(x, y, s);
    exp_lat = model_lat(y, 1 << g) + drop_len;
    wait_cyc = 0;
    while (!in_ready[g] && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk($sformatf("in_ready_idle[g%0d]", g), 64'(in_ready[g]), 64'd1);
    a = x; b = y; in_signed = s; in_valid[g] = 1'b1;
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    a = W'($urandom); b = W'($urandom); in_signed = 1'($urandom);
    cyc = 0;
    while (!out_valid[g] && cyc < 200) begin
      if (in_ready[g]) begin
        chk($sformatf("busy_in_ready[g%0d]", g), 64'(in_ready[g]), 64'd0);
      end
      en = (cyc >= drop_at && cyc < drop_at + drop_len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    en = 1'b1;
    chk($sformatf("latency[g%0d a=%0h b=%0h s=%0d]", g, x, y, s), 64'(cyc), 64'(exp_lat));
    chk($sformatf("product[g%0d a=%0h b=%0h s=%0d]", g, x, y, s), 64'(p[g]), 64'(exp_p));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_valid[g%0d]", g), 64'(out_valid[g]), 64'd1);
      chk($sformatf("hold_in_ready[g%0d]", g), 64'(in_ready[g]), 64'd0);
      chk($sformatf("hold_p[g%0d]", g), 64'(p[g]), 64'(exp_p));
    end
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    out_ready[g] = 1'b0;
    chk($sformatf("release_valid[g%0d]", g), 64'(out_valid[g]), 64'd0);
    chk($sformatf("release_in_ready[g%0d]", g), 64'(in_ready[g]), 64'd1);
    chk($sformatf("p_kept[g%0d]", g), 64'(p[g]), 64'(exp_p));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_signed = 1'b0; a = '0; b = '0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_in_ready[g%0d]", g), 64'(in_ready[g]), 64'd1);
      chk($sformatf("reset_out_valid[g%0d]", g), 64'(out_valid[g]), 64'd0);
      chk($sformatf("reset_p[g%0d]", g), 64'(p[g]), 64'd0);
    end
    rst = 1'b0;

    // Pin the model itself to hand-computed values.
    chk("model_max_x_min", 64'(model_prod(16'sd32767, 16'h8000, 1'b1)), 64'h00000000_C0008000);
    chk("model_min_x_min", 64'(model_prod(16'h8000, 16'h8000, 1'b1)), 64'h00000000_40000000);
    chk("model_u_ffff_sq", 64'(model_prod(16'hFFFF, 16'hFFFF, 1'b0)), 64'h00000000_FFFE0001);
    chk("model_m7_x_123", 64'(model_prod(16'hFFF9, 16'd123, 1'b1)), 64'h00000000_FFFFFCA3);
    chk("model_1000_x_3", 64'(model_prod(16'd1000, 16'd3, 1'b0)), 64'd3000);

    // Directed cases.
    run_op(0, 16'd32767, 16'h8000, 1'b1, 0, 0, 0);
    run_op(0, 16'h8000, 16'h8000, 1'b1, 0, 0, 0);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 0);
    run_op(2, 16'hFFF9, 16'd123, 1'b1, 0, 0, 0);
    run_op(1, 16'h8000, 16'hFFFF, 1'b1, 0, 0, 0);
    run_op(0, 16'd1234, 16'h8001, 1'b0, 10, 0, 0);
    run_op(0, 16'd32767, 16'h8000, 1'b1, 0, 4, 3);
    run_op(0, 16'd1000, 16'd3, 1'b0, 0, 0, 0);
    run_op(0, 16'd1000, 16'd0, 1'b0, 0, 0, 0);
    run_op(2, 16'hFFFF, 16'h0000, 1'b1, 0, 0, 0);

    // Reset mid-BUSY, with en low to show rst wins.
    a = 16'd77; b = 16'hFFFF; in_signed = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_p", 64'(p[0]), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_result", 64'(out_valid[0]), 64'd0);

    // Randomized sweeps on all three chunk widths.
    for (int g = 0; g < 3; g++) begin
      for (int t = 0; t < 25; t++) begin
        run_op(g, W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
               0, int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
